// File: rtl/inst_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
// Instruction field positions match the core's decoder.
package inst_loader_pkg;

  localparam int INST_W = 32;
  localparam int HALF_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  // Opcode field shared with the core's decoder
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  localparam logic [4:0]        OPC_HALT  = 5'b11011;
  localparam logic [INST_W-1:0] HALT_WORD = {OPC_HALT, {(OPC_LSB){1'b0}}};

  // Loader FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HI   = 3'd1;
  localparam state_t ST_LO   = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_PAD  = 3'd4;
  localparam state_t ST_CK   = 3'd5;
  localparam state_t ST_DONE = 3'd6;

endpackage

// File: rtl/inst_loader.sv
// Boot-time program loader: assembles 16-bit halfwords (high half first)
// into 32-bit instructions, writes them sequentially into the 16-entry
// program memory, pads the rest with HALT and holds the core in reset
// until the image is complete.
// Optional build macro INST_LOADER_CHECKSUM_EN adds a trailing checksum
// halfword (two's-complement negation of the wrapping 16-bit sum of all
// data halfwords) and the sticky err_checksum output.
//
// Handshake: a halfword transfers on a posedge where s_valid && s_ready;
// s_data/s_last are sampled only then. s_ready is high in HI, LO (and CK).
module inst_loader
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [HALF_W-1:0] s_data,
  input  logic              s_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   inst_count,
  output logic              err_overflow
`ifdef INST_LOADER_CHECKSUM_EN
  ,
  output logic              err_checksum
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   hi_q, hi_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     inst_count_q, inst_count_d;
  logic                err_overflow_q, err_overflow_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [INST_W-1:0]   im_wdata_q, im_wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                load_done_q, load_done_d;
  logic                xfer;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [HALF_W-1:0]   sum_q, sum_d;
  logic                err_checksum_q, err_checksum_d;
  logic [HALF_W-1:0]   ck_expect;
  assign ck_expect = '0 - sum_q;
  assign s_ready   = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_CK);
`else
  assign s_ready   = (state_q == ST_HI) || (state_q == ST_LO);
`endif

  assign xfer = s_valid && s_ready;

  // Next-state and registered-output computation for the loader FSM
  always_comb begin
    state_d        = state_q;
    hi_d           = hi_q;
    last_d         = last_q;
    addr_d         = addr_q;
    inst_count_d   = inst_count_q;
    err_overflow_d = err_overflow_q;
    im_we_d        = 1'b0;
    im_addr_d      = im_addr_q;
    im_wdata_d     = im_wdata_q;
    core_rst_d     = core_rst_q;
    load_done_d    = load_done_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
    err_checksum_d = err_checksum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d         = '0;
          inst_count_d   = '0;
          err_overflow_d = 1'b0;
          core_rst_d     = 1'b1;
          load_done_d    = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d          = '0;
          err_checksum_d = 1'b0;
`endif
          state_d        = ST_HI;
        end
      end
      ST_HI: begin
        if (xfer) begin
          hi_d    = s_data;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d   = sum_q + s_data;
`endif
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        // Write strobe is registered here so it lands exactly one cycle
        // after the low-half transfer, during WR.
        if (xfer) begin
          last_d       = s_last;
          im_we_d      = 1'b1;
          im_addr_d    = addr_q;
          im_wdata_d   = {hi_q, s_data};
          inst_count_d = inst_count_q + (ADDR_W+1)'(1);
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d        = sum_q + s_data;
`endif
          state_d      = ST_WR;
        end
      end
      ST_WR: begin
        if (last_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = ST_CK;
`else
          if (addr_q != ADDR_MAX) begin
            addr_d     = addr_q + ADDR_W'(1);
            im_we_d    = 1'b1;
            im_addr_d  = addr_q + ADDR_W'(1);
            im_wdata_d = HALT_WORD;
            state_d    = ST_PAD;
          end else begin
            core_rst_d  = 1'b0;
            load_done_d = 1'b1;
            state_d     = ST_DONE;
          end
`endif
        end else if (addr_q == ADDR_MAX) begin
          // Memory full without s_last: truncate, but still release the core
          err_overflow_d = 1'b1;
          core_rst_d     = 1'b0;
          load_done_d    = 1'b1;
          state_d        = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_HI;
        end
      end
      ST_PAD: begin
        if (addr_q == ADDR_MAX) begin
          core_rst_d  = 1'b0;
          load_done_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          addr_d     = addr_q + ADDR_W'(1);
          im_we_d    = 1'b1;
          im_addr_d  = addr_q + ADDR_W'(1);
          im_wdata_d = HALT_WORD;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CK: begin
        if (xfer) begin
          if (s_data == ck_expect) begin
            if (addr_q != ADDR_MAX) begin
              addr_d     = addr_q + ADDR_W'(1);
              im_we_d    = 1'b1;
              im_addr_d  = addr_q + ADDR_W'(1);
              im_wdata_d = HALT_WORD;
              state_d    = ST_PAD;
            end else begin
              core_rst_d  = 1'b0;
              load_done_d = 1'b1;
              state_d     = ST_DONE;
            end
          end else begin
            // Bad image: park in DONE with the core still held in reset
            err_checksum_d = 1'b1;
            state_d        = ST_DONE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      hi_q           <= '0;
      last_q         <= 1'b0;
      addr_q         <= '0;
      inst_count_q   <= '0;
      err_overflow_q <= 1'b0;
      im_we_q        <= 1'b0;
      im_addr_q      <= '0;
      im_wdata_q     <= '0;
      core_rst_q     <= 1'b1;
      load_done_q    <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q          <= '0;
      err_checksum_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      hi_q           <= hi_d;
      last_q         <= last_d;
      addr_q         <= addr_d;
      inst_count_q   <= inst_count_d;
      err_overflow_q <= err_overflow_d;
      im_we_q        <= im_we_d;
      im_addr_q      <= im_addr_d;
      im_wdata_q     <= im_wdata_d;
      core_rst_q     <= core_rst_d;
      load_done_q    <= load_done_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
      err_checksum_q <= err_checksum_d;
`endif
    end
  end

  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign inst_count   = inst_count_q;
  assign err_overflow = err_overflow_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign err_checksum = err_checksum_q;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed load scenarios with random program
// contents, checked against a program-image model kept in the bench.
// Builds with or without INST_LOADER_CHECKSUM_EN.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int WW = ADDR_W + INST_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [HALF_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [INST_W-1:0] im_wdata;
  logic              core_rst;
  logic              load_done;
  logic [ADDR_W:0]   inst_count;
  logic              err_overflow;
  logic              ck_err;

`ifdef INST_LOADER_CHECKSUM_EN
  logic err_checksum;
  assign ck_err = err_checksum;
`else
  assign ck_err = 1'b0;
`endif

  inst_loader dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .inst_count   (inst_count),
    .err_overflow (err_overflow)
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    .err_checksum (err_checksum)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [WW-1:0]     exp_q[$];
  logic [WW-1:0]     got_q[$];
  logic              lat_q[$];
  logic [INST_W-1:0] prog[$];
  logic [HALF_W:0]   hw_q[$];
  int                exp_count;
  logic              exp_ovf;
  logic              exp_ckfail;
  bit                ck_force = 0;
  logic [HALF_W-1:0] ck_val = '0;
  int                n_cmp = 0;
  int                n_bad = 0;

  // Monitor: collect every memory write and, after each low-half
  // transfer, whether the write strobe followed on the next cycle.
  logic phase_lo = 1'b0;
  logic lo_pend  = 1'b0;
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      phase_lo = 1'b0;
      lo_pend  = 1'b0;
    end else begin
      if (lo_pend) lat_q.push_back(im_we);
      lo_pend = 1'b0;
      if (im_we) got_q.push_back({im_addr, im_wdata});
      if (start) phase_lo = 1'b0;
      if (s_valid && s_ready) begin
        if (phase_lo) lo_pend = 1'b1;
        phase_lo = ~phase_lo;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: halfword stream plus expected memory image.
  task automatic plan(input bit has_last);
    int n;
    int written;
    logic [HALF_W-1:0] sum;
    logic [HALF_W-1:0] ck;
    hw_q.delete();
    exp_q.delete();
    n = prog.size();
    sum = '0;
    for (int i = 0; i < n; i++) begin
      logic [INST_W-1:0] w;
      w = prog[i];
      hw_q.push_back({1'b0, w[31:16]});
      hw_q.push_back({(has_last && i == n - 1), w[15:0]});
      sum = sum + w[31:16] + w[15:0];
    end
    exp_ckfail = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    if (has_last) begin
      ck = ck_force ? ck_val : (16'h0000 - sum);
      hw_q.push_back({1'b0, ck});
      exp_ckfail = ((sum + ck) != 16'h0000);
    end
`endif
    written   = (n < DEPTH) ? n : DEPTH;
    exp_count = written;
    exp_ovf   = !has_last && (n >= DEPTH);
    for (int a = 0; a < written; a++) exp_q.push_back({ADDR_W'(a), prog[a]});
    if (has_last && !exp_ckfail)
      for (int a = n; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), HALT_WORD});
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid always; 1: valid toggles each cycle; 2: random valid
  task automatic stream(input int mode, input int budget, output int taken);
    int  cyc;
    logic tk;
    cyc = 0;
    taken = 0;
    while (taken < hw_q.size() && cyc < budget) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      {s_last, s_data} = hw_q[taken];
      @(negedge clk);
      tk = s_valid && s_ready;
      @(posedge clk); #1;
      if (tk) taken++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int cyc;
    logic seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      seen = load_done || ck_err;
      cyc++;
    end
    check({tag, "_end_timeout"}, 64'(seen), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
    for (int i = 0; i < lat_q.size(); i++) check({tag, "_we_latency"}, 64'(lat_q[i]), 64'd1);
    lat_q.delete();
    check({tag, "_inst_count"}, 64'(inst_count), 64'(exp_count));
    check({tag, "_err_overflow"}, 64'(err_overflow), 64'(exp_ovf));
    check({tag, "_load_done"}, 64'(load_done), 64'(!exp_ckfail));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(exp_ckfail));
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    check({tag, "_err_checksum"}, 64'(err_checksum), 64'(exp_ckfail));
`endif
  endtask

  task automatic run_load(input string tag, input bit has_last, input int mode);
    int taken;
    plan(has_last);
    got_q.delete();
    lat_q.delete();
    pulse_start();
    stream(mode, 400, taken);
    check({tag, "_taken"}, 64'(taken), 64'(hw_q.size()));
    wait_end(tag);
    compare(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_im_we"}, 64'(im_we), 64'd0);
    check({tag, "_im_addr"}, 64'(im_addr), 64'd0);
    check({tag, "_im_wdata"}, 64'(im_wdata), 64'd0);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_load_done"}, 64'(load_done), 64'd0);
    check({tag, "_inst_count"}, 64'(inst_count), 64'd0);
    check({tag, "_err_overflow"}, 64'(err_overflow), 64'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    check({tag, "_err_checksum"}, 64'(err_checksum), 64'd0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int taken;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    sys_rst_n = 1'b1;
    @(posedge clk); #1;

    // Three instructions, continuous valid
    prog = '{32'h0840_0005, 32'h1084_0003, 32'hD800_0000};
    run_load("basic", 1'b1, 0);

    // Same image under valid toggling every cycle
    run_load("toggle", 1'b1, 1);

    // Random-length random program with random valid
    prog.delete();
    n = $urandom_range(1, 15);
    for (int i = 0; i < n; i++) prog.push_back($urandom());
    run_load("random", 1'b1, 2);

    // 17 instructions without s_last: truncated at 16, overflow flagged
    prog.delete();
    for (int i = 0; i < DEPTH + 1; i++) prog.push_back($urandom());
    plan(1'b0);
    got_q.delete();
    lat_q.delete();
    pulse_start();
    stream(0, 120, taken);
    check("ovf_taken", 64'(taken), 64'(2 * DEPTH));
    compare("ovf");

    // Exactly 16 instructions, s_last on the 16th: no padding
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom());
    plan(1'b1);
    got_q.delete();
    lat_q.delete();
    pulse_start();
    stream(0, 200, taken);
    check("full_taken", 64'(taken), 64'(hw_q.size()));
`ifndef INST_LOADER_CHECKSUM_EN
    check("full_final_we", 64'(im_we), 64'd1);
    check("full_final_addr", 64'(im_addr), 64'(DEPTH - 1));
    check("full_done_early", 64'(load_done), 64'd0);
    @(posedge clk); #1;
    check("full_done_latency", 64'(load_done), 64'd1);
    check("full_no_pad", 64'(im_we), 64'd0);
`endif
    wait_end("full");
    compare("full");

    // Reset while the second write is in flight
    prog.delete();
    for (int i = 0; i < 2; i++) prog.push_back($urandom());
    plan(1'b0);
    got_q.delete();
    lat_q.delete();
    pulse_start();
    stream(0, 40, taken);
    check("rst_inflight_we", 64'(im_we), 64'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    check("rst_prior_writes", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("rst_first_write", 64'(got_q[0]), 64'(exp_q[0]));
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    @(posedge clk); #1;
    prog.delete();
    prog.push_back($urandom());
    run_load("after_rst", 1'b1, 0);

`ifdef INST_LOADER_CHECKSUM_EN
    // Known-good checksum for 0x0840,0x0005
    prog = '{32'h0840_0005};
    ck_force = 1;
    ck_val = 16'hF7BB;
    run_load("ck_pass", 1'b1, 0);
    check("ck_pass_flag", 64'(err_checksum), 64'd0);
    // Same stream with a wrong checksum
    ck_val = 16'h0000;
    run_load("ck_fail", 1'b1, 0);
    check("ck_fail_flag", 64'(err_checksum), 64'd1);
    check("ck_fail_core_rst", 64'(core_rst), 64'd1);
    ck_force = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
